// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation encoding and control bundle.
package rv_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0033;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic reg_we;
    logic use_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
  } id_ctrl_t;

  // alt_sub selects SUB for funct3=000, alt_sra selects SRA for funct3=101.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3,
                                              input logic alt_sub,
                                              input logic alt_sra);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction for all RV32I formats, sign-extended to XLEN.
module imm_gen
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic sign;
  assign sign = inst[31];

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        imm = {{(XLEN-12){sign}}, inst[31:20]};
      OPC_STORE:
        imm = {{(XLEN-12){sign}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{(XLEN-13){sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{(XLEN-32){sign}}, inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{(XLEN-21){sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID capture, field/control decode, regfile read and ID/EX register
// with mispredict flush, data-cache freeze and load-use bubble insertion.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter logic [31:0] NOP_WORD = rv_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mispredict,
  input  logic            mstall,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] PC_f,
  input  logic [XLEN-1:0] PC_fp4,
  input  logic            branch_prediction,
  input  logic [XLEN-1:0] branch_target,
  output logic [RA_W-1:0] rf_raddr1,
  output logic [RA_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic            hazard_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcp4,
  output logic [XLEN-1:0] id_pred_target,
  output logic [RA_W-1:0] id_rs1,
  output logic [RA_W-1:0] id_rs2,
  output logic [RA_W-1:0] id_rd,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [3:0]      id_alu_op,
  output logic [2:0]      id_funct3,
  output logic [8:0]      id_ctrl,
  output logic            id_pred_taken,
  output logic            id_illegal
);

  import rv_pkg::*;

  logic [31:0]     if_inst;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pcp4;
  logic [XLEN-1:0] if_target;
  logic            if_pred;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RA_W-1:0] f_rd;
  logic [RA_W-1:0] f_rs1;
  logic [RA_W-1:0] f_rs2;

  assign opcode = if_inst[6:0];
  assign f_rd   = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign f_rs1  = if_inst[19:15];
  assign f_rs2  = if_inst[24:20];
  assign funct7 = if_inst[31:25];

  id_ctrl_t        dec_ctrl;
  alu_op_t         dec_alu;
  logic            dec_illegal;
  logic            use_rs1;
  logic            use_rs2;
  logic            writes_rd;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic [RA_W-1:0] dec_rd;
  logic [XLEN-1:0] dec_imm;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (if_inst),
    .imm  (dec_imm)
  );

  always_comb begin
    dec_ctrl    = '0;
    dec_alu     = ALU_ADD;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    writes_rd   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_ctrl.is_lui  = 1'b1;
        dec_ctrl.use_imm = 1'b1;
        dec_alu          = ALU_PASSB;
        writes_rd        = 1'b1;
      end
      OPC_AUIPC: begin
        dec_ctrl.is_auipc = 1'b1;
        dec_ctrl.use_imm  = 1'b1;
        writes_rd         = 1'b1;
      end
      OPC_JAL: begin
        dec_ctrl.is_jal  = 1'b1;
        dec_ctrl.use_imm = 1'b1;
        writes_rd        = 1'b1;
      end
      OPC_JALR: begin
        dec_ctrl.is_jalr = 1'b1;
        dec_ctrl.use_imm = 1'b1;
        use_rs1          = 1'b1;
        writes_rd        = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ctrl.is_branch = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
        case (funct3[2:1])
          2'b10:   dec_alu = ALU_SLT;
          2'b11:   dec_alu = ALU_SLTU;
          default: dec_alu = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        dec_ctrl.is_load = 1'b1;
        dec_ctrl.use_imm = 1'b1;
        use_rs1          = 1'b1;
        writes_rd        = 1'b1;
      end
      OPC_STORE: begin
        dec_ctrl.is_store = 1'b1;
        dec_ctrl.use_imm  = 1'b1;
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
      end
      OPC_OPIMM: begin
        dec_ctrl.use_imm = 1'b1;
        use_rs1          = 1'b1;
        writes_rd        = 1'b1;
        dec_alu          = alu_from_funct3(funct3, 1'b0, if_inst[30]);
        if (funct3 == 3'b001 && funct7 != FUNCT7_BASE)
          dec_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
          dec_illegal = 1'b1;
      end
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
        dec_alu   = alu_from_funct3(funct3, if_inst[30], if_inst[30]);
        if (funct7 == FUNCT7_ALT) begin
          if (funct3 != 3'b000 && funct3 != 3'b101)
            dec_illegal = 1'b1;
        end else if (funct7 != FUNCT7_BASE) begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal words carry no register usage so they can neither write nor trigger a hazard.
    if (dec_illegal) begin
      dec_ctrl  = '0;
      dec_alu   = ALU_ADD;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
    end
    dec_ctrl.reg_we = writes_rd && (f_rd != '0);
  end

  assign dec_rs1   = use_rs1   ? f_rs1 : '0;
  assign dec_rs2   = use_rs2   ? f_rs2 : '0;
  assign dec_rd    = writes_rd ? f_rd  : '0;
  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  id_ctrl_t ctrl_q;
  alu_op_t  alu_q;
  assign id_ctrl   = ctrl_q;
  assign id_alu_op = alu_q;

  logic load_use;
  logic idex_bubble;
  logic idex_load;

  assign load_use = if_valid && id_valid && ctrl_q.is_load && (id_rd != '0) &&
                    ((id_rd == dec_rs1) || (id_rd == dec_rs2));
  assign hazard_stall = load_use && !mstall && !mispredict && !rst;

  assign idex_bubble = rst || mispredict || (!mstall && (load_use || !if_valid));
  assign idex_load   = !mstall;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_inst   <= NOP_WORD;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_pcp4   <= '0;
      if_target <= '0;
      if_pred   <= 1'b0;
    end else if (mispredict) begin
      if_inst  <= NOP_WORD;
      if_valid <= 1'b0;
      if_pred  <= 1'b0;
    end else if (!mstall && !load_use) begin
      if_inst   <= instruction[31:0];
      if_valid  <= (instruction[31:0] != NOP_WORD);
      if_pc     <= PC_f;
      if_pcp4   <= PC_fp4;
      if_target <= branch_target;
      if_pred   <= branch_prediction;
    end
  end

  always_ff @(posedge clk) begin
    if (idex_bubble) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_pcp4        <= '0;
      id_pred_target <= '0;
      id_rs1         <= '0;
      id_rs2         <= '0;
      id_rd          <= '0;
      id_rs1_val     <= '0;
      id_rs2_val     <= '0;
      id_imm         <= '0;
      alu_q          <= ALU_ADD;
      id_funct3      <= '0;
      ctrl_q         <= '0;
      id_pred_taken  <= 1'b0;
      id_illegal     <= 1'b0;
    end else if (idex_load) begin
      id_valid       <= 1'b1;
      id_pc          <= if_pc;
      id_pcp4        <= if_pcp4;
      id_pred_target <= if_target;
      id_rs1         <= dec_rs1;
      id_rs2         <= dec_rs2;
      id_rd          <= dec_rd;
      id_rs1_val     <= rf_rdata1;
      id_rs2_val     <= rf_rdata2;
      id_imm         <= dec_imm;
      alu_q          <= dec_alu;
      id_funct3      <= funct3;
      ctrl_q         <= dec_ctrl;
      id_pred_taken  <= if_pred;
      id_illegal     <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage using hand-computed expected values.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, mispredict, mstall;
  logic [31:0] instruction, PC_f, PC_fp4, branch_target;
  logic        branch_prediction;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        hazard_stall, id_valid, id_pred_taken, id_illegal;
  logic [31:0] id_pc, id_pcp4, id_pred_target, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic [8:0]  id_ctrl;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP   = 32'h0000_0033;
  localparam logic [31:0] ADDI  = 32'hFFD0_8293; // addi x5,x1,-3
  localparam logic [31:0] LW7   = 32'h0001_2383; // lw x7,0(x2)
  localparam logic [31:0] ADD7  = 32'h0033_8433; // add x8,x7,x3
  localparam logic [31:0] LW0   = 32'h0001_2003; // lw x0,0(x2)
  localparam logic [31:0] ADD0  = 32'h0030_0433; // add x8,x0,x3
  localparam logic [31:0] BEQ   = 32'hFE20_8CE3; // beq x1,x2,-8
  localparam logic [31:0] SUB   = 32'h4020_81B3; // sub x3,x1,x2
  localparam logic [31:0] SRAI  = 32'h4030_D293; // srai x5,x1,3
  localparam logic [31:0] LUI   = 32'h1234_54B7; // lui x9,0x12345
  localparam logic [31:0] ILL   = 32'h0000_008B; // custom-0 opcode
  localparam logic [31:0] MUL   = 32'h0233_8433; // OP with funct7=01

  decode_stage #(.XLEN(32), .RA_W(5), .NOP_WORD(32'h0000_0033)) dut (
    .clk(clk), .rst(rst), .mispredict(mispredict), .mstall(mstall),
    .instruction(instruction), .PC_f(PC_f), .PC_fp4(PC_fp4),
    .branch_prediction(branch_prediction), .branch_target(branch_target),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .hazard_stall(hazard_stall), .id_valid(id_valid),
    .id_pc(id_pc), .id_pcp4(id_pcp4), .id_pred_target(id_pred_target),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_ctrl(id_ctrl),
    .id_pred_taken(id_pred_taken), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // Register file stand-in: each register reads as 0x1000_0000 + index.
  assign rf_rdata1 = 32'h1000_0000 + {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'h1000_0000 + {27'd0, rf_raddr2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc,
                       input logic pred, input logic [31:0] tgt);
    instruction       = inst;
    PC_f              = pc;
    PC_fp4            = pc + 32'd4;
    branch_prediction = pred;
    branch_target     = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mispredict = 1'b0; mstall = 1'b0;
    fetch(NOP, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ctrl", {23'd0, id_ctrl}, 32'd0);
    chk("rst_illegal", {31'd0, id_illegal}, 32'd0);
    chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    rst = 1'b0;

    // ADDI two-cycle latency
    fetch(ADDI, 32'h100, 1'b0, 32'h0);
    tick();
    fetch(NOP, 32'h104, 1'b0, 32'h0);
    tick();
    chk("addi_valid", {31'd0, id_valid}, 32'd1);
    chk("addi_rd", {27'd0, id_rd}, 32'd5);
    chk("addi_rs1", {27'd0, id_rs1}, 32'd1);
    chk("addi_rs2", {27'd0, id_rs2}, 32'd0);
    chk("addi_imm", id_imm, 32'hFFFF_FFFD);
    chk("addi_alu", {28'd0, id_alu_op}, 32'd0);
    chk("addi_ctrl", {23'd0, id_ctrl}, 32'h180);
    chk("addi_pc", id_pc, 32'h100);
    chk("addi_pcp4", id_pcp4, 32'h104);
    chk("addi_rs1val", id_rs1_val, 32'h1000_0001);
    tick();
    chk("nop_valid", {31'd0, id_valid}, 32'd0);

    // load-use on x7
    fetch(LW7, 32'h200, 1'b0, 32'h0);
    tick();
    fetch(ADD7, 32'h204, 1'b0, 32'h0);
    tick();
    fetch(NOP, 32'h208, 1'b0, 32'h0);
    #1;
    chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    chk("lw_ctrl", {23'd0, id_ctrl}, 32'h1C0);
    chk("lw_rd", {27'd0, id_rd}, 32'd7);
    tick();
    chk("lu_bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("lu_hazard_clear", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, id_valid}, 32'd1);
    chk("lu_add_rs1", {27'd0, id_rs1}, 32'd7);
    chk("lu_add_rs2", {27'd0, id_rs2}, 32'd3);
    chk("lu_add_rd", {27'd0, id_rd}, 32'd8);
    chk("lu_add_pc", id_pc, 32'h204);
    chk("lu_add_rs1val", id_rs1_val, 32'h1000_0007);
    chk("lu_add_ctrl", {23'd0, id_ctrl}, 32'h100);

    // load to x0 never stalls
    fetch(LW0, 32'h300, 1'b0, 32'h0);
    tick();
    fetch(ADD0, 32'h304, 1'b0, 32'h0);
    tick();
    fetch(NOP, 32'h308, 1'b0, 32'h0);
    #1;
    chk("x0_hazard", {31'd0, hazard_stall}, 32'd0);
    chk("lw0_ctrl", {23'd0, id_ctrl}, 32'h0C0);
    chk("lw0_rd", {27'd0, id_rd}, 32'd0);
    tick();
    chk("x0_add_valid", {31'd0, id_valid}, 32'd1);
    chk("x0_add_pc", id_pc, 32'h304);

    // mstall freeze with a pending load-use, then mispredict during the stall
    fetch(LW7, 32'h400, 1'b0, 32'h0);
    tick();
    fetch(ADD7, 32'h404, 1'b0, 32'h0);
    tick();
    mstall = 1'b1;
    fetch(SUB, 32'h408, 1'b0, 32'h0);
    #1;
    chk("ms_hazard_forced0", {31'd0, hazard_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_pc", id_pc, 32'h400);
      chk("ms_ctrl", {23'd0, id_ctrl}, 32'h1C0);
      chk("ms_valid", {31'd0, id_valid}, 32'd1);
      chk("ms_hazard", {31'd0, hazard_stall}, 32'd0);
      chk("ms_ifid_raddr1", {27'd0, rf_raddr1}, 32'd7);
    end
    mispredict = 1'b1;
    tick();
    chk("mp_valid", {31'd0, id_valid}, 32'd0);
    chk("mp_ctrl", {23'd0, id_ctrl}, 32'd0);
    chk("mp_ifid_raddr1", {27'd0, rf_raddr1}, 32'd0);
    mispredict = 1'b0;
    mstall = 1'b0;
    fetch(NOP, 32'h500, 1'b0, 32'h0);
    tick();
    chk("mp_bubble_valid", {31'd0, id_valid}, 32'd0);

    // branch with prediction passthrough
    fetch(BEQ, 32'h500, 1'b1, 32'h4F8);
    tick();
    fetch(NOP, 32'h504, 1'b0, 32'h0);
    tick();
    chk("beq_valid", {31'd0, id_valid}, 32'd1);
    chk("beq_ctrl", {23'd0, id_ctrl}, 32'h010);
    chk("beq_imm", id_imm, 32'hFFFF_FFF8);
    chk("beq_rd", {27'd0, id_rd}, 32'd0);
    chk("beq_rs1", {27'd0, id_rs1}, 32'd1);
    chk("beq_rs2", {27'd0, id_rs2}, 32'd2);
    chk("beq_rs2val", id_rs2_val, 32'h1000_0002);
    chk("beq_pred", {31'd0, id_pred_taken}, 32'd1);
    chk("beq_tgt", id_pred_target, 32'h4F8);

    // back-to-back ALU variants and illegal words
    fetch(SUB, 32'h600, 1'b0, 32'h0);
    tick();
    fetch(SRAI, 32'h604, 1'b0, 32'h0);
    tick();
    chk("sub_alu", {28'd0, id_alu_op}, 32'd1);
    chk("sub_rd", {27'd0, id_rd}, 32'd3);
    chk("sub_ctrl", {23'd0, id_ctrl}, 32'h100);
    fetch(LUI, 32'h608, 1'b0, 32'h0);
    tick();
    chk("srai_alu", {28'd0, id_alu_op}, 32'd7);
    chk("srai_imm", id_imm, 32'h0000_0403);
    chk("srai_illegal", {31'd0, id_illegal}, 32'd0);
    fetch(ILL, 32'h60C, 1'b0, 32'h0);
    tick();
    chk("lui_alu", {28'd0, id_alu_op}, 32'd10);
    chk("lui_imm", id_imm, 32'h1234_5000);
    chk("lui_ctrl", {23'd0, id_ctrl}, 32'h182);
    chk("lui_rd", {27'd0, id_rd}, 32'd9);
    fetch(MUL, 32'h610, 1'b0, 32'h0);
    tick();
    chk("ill_opc_illegal", {31'd0, id_illegal}, 32'd1);
    chk("ill_opc_valid", {31'd0, id_valid}, 32'd1);
    chk("ill_opc_ctrl", {23'd0, id_ctrl}, 32'd0);
    chk("ill_opc_rd", {27'd0, id_rd}, 32'd0);
    fetch(ADDI, 32'h614, 1'b0, 32'h0);
    tick();
    chk("ill_f7_illegal", {31'd0, id_illegal}, 32'd1);
    chk("ill_f7_ctrl", {23'd0, id_ctrl}, 32'd0);
    chk("ill_f7_pc", id_pc, 32'h610);

    // reset mid-stream
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_illegal", {31'd0, id_illegal}, 32'd0);
    chk("mrst_ctrl", {23'd0, id_ctrl}, 32'd0);
    chk("mrst_pc", id_pc, 32'd0);
    chk("mrst_imm", id_imm, 32'd0);
    chk("mrst_raddr1", {27'd0, rf_raddr1}, 32'd0);
    chk("mrst_hazard", {31'd0, hazard_stall}, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
